// File: rtl/fft_pkg.sv
// Shared constants, FSM state encoding and output-pipeline entry layout for the
// 32-point MDC FFT front-end controller.
package fft_pkg;

    localparam int N     = 32;
    localparam int LOG2N = 5;
    localparam int HALF  = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    // One butterfly output pair in flight: valid, pair index, last-of-frame
    typedef struct packed {
        logic                 v;
        logic [LOG2N-2:0]     idx;
        logic                 last;
    } pipe_ent_t;

    localparam int ENT_W = $bits(pipe_ent_t);

endpackage

// File: rtl/fft_ctrl_pipe.sv
// LATENCY-deep shift register that carries {v, idx, last} alongside the FFT datapath
// so the controller can flag outputs; synchronous clear drops everything in flight.
module fft_ctrl_pipe
    import fft_pkg::*;
#(
    parameter int LATENCY = 24
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [ENT_W-1:0] i_ent,
    output logic [ENT_W-1:0] o_ent
);

    logic [ENT_W-1:0] r_sr [LATENCY];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < LATENCY; i++) r_sr[i] <= '0;
        end else begin
            r_sr[0] <= i_ent;
            for (int i = 1; i < LATENCY; i++) r_sr[i] <= r_sr[i-1];
        end
    end

    assign o_ent = r_sr[LATENCY-1];

endmodule

// File: rtl/fft32_mdc_ctrl.sv
// Sequencer for the 32-point MDC FFT front end: sample counter, commutator/twiddle decode,
// flush timer, gap detection. Define FFT_CTRL_ERR_CNT_EN to add the saturating err_cnt port.
module fft32_mdc_ctrl
    import fft_pkg::*;
#(
    parameter int LATENCY = 24,
    parameter int ERR_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             flag_in_com1,
    output logic             flag_in_com2,
    output logic             flag_switch_state2_1,
    output logic [3:0]       rom_16_counter,
    output logic             out_valid,
    output logic [3:0]       out_index,
    output logic             frame_done,
    output logic             busy,
    output logic             err_gap
`ifdef FFT_CTRL_ERR_CNT_EN
    ,
    output logic [ERR_W-1:0] err_cnt
`endif
);

    if (LATENCY < 1 || ERR_W < 1) begin : g_param_check
        $error("fft32_mdc_ctrl: LATENCY and ERR_W must be >= 1");
    end

    localparam int               FW         = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [FW-1:0]    FLUSH_LAST = FW'(LATENCY - 1);

    state_t            r_state, w_state_nxt;
    logic [LOG2N-1:0]  r_cnt, w_cnt_nxt;
    logic [FW-1:0]     r_flush, w_flush_nxt;
    logic              r_err_gap, w_gap;
    logic              w_run, w_accept;
    pipe_ent_t         w_push, w_pop;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_flush   <= '0;
            r_err_gap <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_flush   <= w_flush_nxt;
            r_err_gap <= w_gap;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_flush_nxt = r_flush;
        w_gap       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (in_valid) begin
                    w_state_nxt = ST_RUN;
                    w_cnt_nxt   = LOG2N'(1);
                end
            end
            ST_RUN: begin
                if (in_valid) begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end else begin
                    // A drop exactly on the frame boundary (cnt wrapped to 0) is a clean end
                    w_state_nxt = ST_FLUSH;
                    w_cnt_nxt   = '0;
                    w_flush_nxt = '0;
                    w_gap       = (r_cnt != '0);
                end
            end
            ST_FLUSH: begin
                if (r_flush == FLUSH_LAST) w_state_nxt = ST_IDLE;
                else                       w_flush_nxt = r_flush + 1'b1;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign w_run          = (r_state == ST_RUN);
    assign in_ready       = (r_state != ST_FLUSH);
    assign busy           = (r_state != ST_IDLE);
    assign flag_in_com1   = w_run & ~r_cnt[LOG2N-1];
    assign flag_in_com2   = w_run &  r_cnt[LOG2N-1];
    assign rom_16_counter = flag_in_com2 ? r_cnt[LOG2N-2:0] : '0;
    assign err_gap        = r_err_gap;
    assign w_accept       = in_valid & in_ready;

    // Only second-half samples produce a butterfly output pair
    always_comb begin
        w_push      = '0;
        w_push.v    = w_accept & r_cnt[LOG2N-1];
        w_push.idx  = w_push.v ? r_cnt[LOG2N-2:0] : '0;
        w_push.last = w_push.v & (r_cnt == LOG2N'(N - 1));
    end

    fft_ctrl_pipe #(
        .LATENCY (LATENCY)
    ) u_pipe (
        .clk   (clk),
        .rst   (rst),
        .i_ent (w_push),
        .o_ent (w_pop)
    );

    assign out_valid            = w_pop.v;
    assign out_index            = w_pop.idx;
    assign frame_done           = w_pop.v & w_pop.last;
    assign flag_switch_state2_1 = w_pop.idx[3];

`ifdef FFT_CTRL_ERR_CNT_EN
    logic [ERR_W-1:0] r_err_cnt;

    always_ff @(posedge clk) begin
        if (rst)                                          r_err_cnt <= '0;
        else if (r_err_gap && (r_err_cnt != {ERR_W{1'b1}})) r_err_cnt <= r_err_cnt + 1'b1;
    end

    assign err_cnt = r_err_cnt;
`endif

endmodule
